run_detector: RTL and testbench

Parametrised one-hot run-length detector on a serial input `w`. It flags when the last `RUN_LEN` sampled bits are all 0 or all 1, with per-polarity enable, a sample-enable gate, a saturating run counter and a hit event counter. It generalises the fixed two-in-a-row one-hot detector and slots in wherever the design needs serial pattern or run qualification.

---
 rtl/run_detector_pkg.sv | 20 ++
 rtl/run_detector_dff.sv | 19 +
 rtl/run_detector.sv | 94 +++++++++
 tb/tb_run_detector.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/run_detector_pkg.sv
// Shared index helpers and parameter legality rules for the one-hot run detector.
package run_det_pkg;

    localparam int IDLE_IDX = 0;

    function automatic int zidx(input int k);
        return k;
    endfunction

    function automatic int oidx(input int run_len, input int k);
        return run_len + k;
    endfunction

    // Counter must be able to represent a full run before it saturates.
    function automatic bit params_legal(input int run_len, input int cnt_w);
        return (run_len >= 1) && (cnt_w >= 1) && (cnt_w <= 30) &&
               (((1 << cnt_w) - 1) >= run_len);
    endfunction

endpackage

// File: rtl/run_detector_dff.sv
// Single state flop with enable and a parametrised synchronous reset value.
module dff #(
    parameter logic Default = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= Default;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/run_detector.sv
// One-hot run-length detector: flags runs of RUN_LEN equal bits on w, counts run length and hits.
module run_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 w,
    input  logic [1:0]           mode,
    input  logic                 clr,
    output logic [2*RUN_LEN:0]   state,
    output logic                 z,
    output logic                 hit,
    output logic [CNT_W-1:0]     run_cnt,
    output logic [CNT_W-1:0]     hit_cnt
);

    localparam int S  = 2 * RUN_LEN + 1;
    localparam int Z1 = zidx(1);
    localparam int ZN = zidx(RUN_LEN);
    localparam int O1 = oidx(RUN_LEN, 1);
    localparam int ON = oidx(RUN_LEN, RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (!params_legal(RUN_LEN, CNT_W)) begin : g_bad_params
        $error("run_detector: illegal RUN_LEN/CNT_W combination");
    end

    logic [S-1:0] nxt;
    logic         any_zero;
    logic         any_one;
    logic         pol_change;
    logic         hit_d;

    assign any_zero = |state[ZN:Z1];
    assign any_one  = |state[ON:O1];

    // IDLE is only ever left; the terminal states feed back into themselves.
    assign nxt[IDLE_IDX] = 1'b0;

    for (genvar k = 1; k <= RUN_LEN; k++) begin : g_next
        logic z_pre;
        logic o_pre;
        assign z_pre = ((k == 1) ? (state[IDLE_IDX] | any_one) : state[zidx(k-1)]) |
                       ((k == RUN_LEN) ? state[ZN] : 1'b0);
        assign o_pre = ((k == 1) ? (state[IDLE_IDX] | any_zero) : state[oidx(RUN_LEN, k-1)]) |
                       ((k == RUN_LEN) ? state[ON] : 1'b0);
        assign nxt[zidx(k)]         = ~w & z_pre;
        assign nxt[oidx(RUN_LEN, k)] = w & o_pre;
    end

    for (genvar b = 0; b < S; b++) begin : g_state
        dff #(
            .Default((b == IDLE_IDX) ? 1'b1 : 1'b0)
        ) u_dff (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .d     (nxt[b]),
            .q     (state[b])
        );
    end

    assign z = (state[ZN] & mode[0]) | (state[ON] & mode[1]);

    assign pol_change = (w & any_zero) | (~w & any_one);
    assign hit_d = en & (((nxt[ZN] & ~state[ZN]) & mode[0]) |
                         ((nxt[ON] & ~state[ON]) & mode[1]));

    // hit_cnt tracks hit in the same cycle, so clr on a hit edge leaves it at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit     <= 1'b0;
            run_cnt <= '0;
            hit_cnt <= '0;
        end else begin
            hit <= hit_d;
            if (en) begin
                if (state[IDLE_IDX] || pol_change)
                    run_cnt <= CNT_W'(1);
                else if (run_cnt != CNT_MAX)
                    run_cnt <= run_cnt + CNT_W'(1);
            end
            if (clr)
                hit_cnt <= '0;
            else if (hit_d)
                hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_run_detector.sv
// Randomised and directed check of run_detector (N=2/W=8 and N=3/W=2) against a run-length model.
module tb_run_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, w, clr;
    logic [1:0] mode;

    logic [4:0] state2;
    logic       z2, hit2;
    logic [7:0] rc2, hc2;
    logic [6:0] state3;
    logic       z3, hit3;
    logic [1:0] rc3, hc3;

    run_detector #(.RUN_LEN(2), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr(clr),
        .state(state2), .z(z2), .hit(hit2), .run_cnt(rc2), .hit_cnt(hc2)
    );

    run_detector #(.RUN_LEN(3), .CNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr(clr),
        .state(state3), .z(z3), .hit(hit3), .run_cnt(rc3), .hit_cnt(hc3)
    );

    int checks   = 0;
    int failures = 0;

    // Model: a run is just (started, polarity, unbounded length); hits are counted modulo 2^W.
    int m_n[2]  = '{2, 3};
    int m_wd[2] = '{8, 2};
    bit m_started[2];
    bit m_pol[2];
    int m_run[2];
    bit m_hit[2];
    int m_hits[2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelEdge(input int i);
        if (reset) begin
            m_started[i] = 1'b0;
            m_run[i]     = 0;
            m_hit[i]     = 1'b0;
            m_hits[i]    = 0;
        end else begin
            m_hit[i] = 1'b0;
            if (en) begin
                if (!m_started[i] || (w != m_pol[i])) begin
                    m_started[i] = 1'b1;
                    m_pol[i]     = w;
                    m_run[i]     = 1;
                end else begin
                    m_run[i]++;
                end
                m_hit[i] = (m_run[i] == m_n[i]) && mode[m_pol[i]];
            end
            if (clr)
                m_hits[i] = 0;
            else if (m_hit[i])
                m_hits[i] = (m_hits[i] + 1) % (1 << m_wd[i]);
        end
    endtask

    task automatic checkInstance(input int i, input logic [31:0] st, input logic zv, input logic hv,
                                 input logic [31:0] rc, input logic [31:0] hc);
        int          n, len, idx, cmax;
        logic [31:0] one;
        n    = m_n[i];
        cmax = (1 << m_wd[i]) - 1;
        len  = (m_run[i] < n) ? m_run[i] : n;
        idx  = !m_started[i] ? 0 : (m_pol[i] ? n + len : len);
        one  = 32'd1;
        checkOutput($sformatf("N%0d state", n), st, one << idx);
        checkOutput($sformatf("N%0d z", n), 32'(zv),
                    32'(m_started[i] && (m_run[i] >= n) && mode[m_pol[i]]));
        checkOutput($sformatf("N%0d hit", n), 32'(hv), 32'(m_hit[i]));
        checkOutput($sformatf("N%0d run_cnt", n), rc, 32'((m_run[i] < cmax) ? m_run[i] : cmax));
        checkOutput($sformatf("N%0d hit_cnt", n), hc, 32'(m_hits[i]));
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic wi,
                                 input logic [1:0] m, input logic c);
        reset = r;
        en    = e;
        w     = wi;
        mode  = m;
        clr   = c;
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        #1;
        checkInstance(0, 32'(state2), z2, hit2, 32'(rc2), 32'(hc2));
        checkInstance(1, 32'(state3), z3, hit3, 32'(rc3), 32'(hc3));
    endtask

    initial begin
        logic [4:0]  seq5;
        logic [9:0]  seq10;
        logic [1:0]  rmode;
        logic        rw;

        reset = 1'b1; en = 1'b0; w = 1'b0; mode = 2'b00; clr = 1'b0;
        applyStimulus(1, 0, 0, 2'b11, 0);
        applyStimulus(1, 1, 1, 2'b11, 0);

        // w = 0,0,0,1,1 with both polarities, then zero runs only
        seq5 = 5'b11000;
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, seq5[i], 2'b11, 0);
        applyStimulus(1, 0, 0, 2'b01, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, seq5[i], 2'b01, 0);

        // Hold from O1 while w toggles with en low
        applyStimulus(1, 0, 0, 2'b11, 0);
        applyStimulus(0, 1, 1, 2'b11, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, i[0], 2'b11, 0);

        // Long one run: saturation on the narrow instance
        applyStimulus(1, 0, 0, 2'b10, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 2'b10, 0);

        // Reset mid-run from O2 with en and w high
        applyStimulus(1, 0, 0, 2'b11, 0);
        applyStimulus(0, 1, 1, 2'b11, 0);
        applyStimulus(0, 1, 1, 2'b11, 0);
        applyStimulus(1, 1, 1, 2'b11, 0);

        // Five hits on N=2, then clr on the edge producing the sixth
        seq10 = 10'b0011001100;
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, seq10[i], 2'b11, 0);
        applyStimulus(0, 1, 1, 2'b11, 0);
        applyStimulus(0, 1, 1, 2'b11, 1);
        applyStimulus(0, 1, 1, 2'b11, 0);

        rmode = 2'b11;
        rw    = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) rw = ~rw;
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8), rw, rmode,
                          ($urandom_range(0, 24) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
